relay_rx_framer: RTL



---
 rtl/relay_pkg.sv | 29 ++
 rtl/maj8_filter.sv | 35 +++
 rtl/relay_rx_framer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
// Shared constants for the relay receive framer: simulate-mode codes,
// framing patterns, sample-tick divide value and FSM state type.
package relay_pkg;

  localparam logic [2:0] MODE_SNIFFER       = 3'b000;
  localparam logic [2:0] MODE_TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] MODE_TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] MODE_READER_LISTEN = 3'b011;
  localparam logic [2:0] MODE_READER_MOD    = 3'b100;
  localparam logic [2:0] MODE_FAKE_READER   = 3'b101;
  localparam logic [2:0] MODE_FAKE_TAG      = 3'b110;

  localparam logic [7:0]  START_FR = 8'hC0;
  localparam logic [7:0]  START_FT = 8'hF0;
  localparam logic [15:0] END_ZERO = 16'h0000;
  localparam logic [15:0] END_FR   = 16'hC000;

  localparam logic [3:0] TICK_DIV = 4'd8;

  typedef enum logic {
    ST_LISTEN = 1'b0,
    ST_MOD    = 1'b1
  } state_e;

  function automatic logic is_relay(input logic [2:0] m);
    return (m == MODE_FAKE_READER) || (m == MODE_FAKE_TAG);
  endfunction

endpackage

// File: rtl/maj8_filter.sv
// Two-flop synchroniser followed by an 8-sample majority filter:
// filt is high when at least 4 of the last 8 synchronised samples are high.
module maj8_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt
);

  logic [1:0] sync_q, sync_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] pop;

  always_comb begin
    sync_d  = {sync_q[0], din};
    shift_d = {shift_q[6:0], sync_q[1]};
    pop     = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'b000, shift_q[i]};
    end
  end

  assign filt = pop[3] | pop[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      shift_q <= 8'h00;
    end else begin
      sync_q  <= sync_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/relay_rx_framer.sv
// Relay link receive framer: samples the filtered relay line every 16 clocks,
// detects fake-reader / fake-tag frame start and end, and drives mod_type.
module relay_rx_framer
  import relay_pkg::*;
#(
  parameter int FRAME_TICKS_MAX = 4095
) (
  input  logic       ck_1356meg,
  input  logic       nrst,
  input  logic       relay_in,
  input  logic [2:0] mode,
  output logic [2:0] mod_type,
  output logic       data_bit,
  output logic       bit_strobe,
  output logic       frame_active,
  output logic       frame_error
);

  localparam logic [11:0] TICKS_MAX  = 12'(FRAME_TICKS_MAX);
  localparam logic [23:0] FR_START   = {16'h0000, START_FR};
  localparam logic [23:0] FT_START   = {16'h0000, START_FT};
  localparam logic [23:0] FR_END_A   = {8'h00, END_ZERO};
  localparam logic [23:0] FR_END_B   = {END_FR, 8'h00};

  logic        filt;
  logic [3:0]  div_q, div_d;
  logic [2:0]  mode_q;
  state_e      state_q, state_d;
  logic [23:0] hist_q, hist_d, hist_shift;
  logic [2:0]  bit_cnt_q, bit_cnt_d, bit_inc;
  logic [11:0] tick_cnt_q, tick_cnt_d, tick_inc;
  logic [2:0]  mod_type_q, mod_type_d;
  logic        bit_strobe_q, frame_error_q, frame_error_d;
  logic        tick, fake_reader, start_hit, end_hit;

  maj8_filter u_filter (
    .clk   (ck_1356meg),
    .rst_n (nrst),
    .din   (relay_in),
    .filt  (filt)
  );

  assign tick        = (div_q == TICK_DIV);
  assign fake_reader = (mode == MODE_FAKE_READER);

  always_comb begin
    div_d         = div_q + 4'd1;
    hist_shift    = {hist_q[22:0], filt};
    bit_inc       = bit_cnt_q + 3'd1;
    tick_inc      = tick_cnt_q + 12'd1;
    start_hit     = fake_reader ? (hist_shift == FR_START) : (hist_shift == FT_START);
    end_hit       = fake_reader ? ((hist_shift == FR_END_A) || (hist_shift == FR_END_B))
                                : (hist_shift[15:0] == END_ZERO);
    hist_d        = hist_q;
    bit_cnt_d     = bit_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    state_d       = state_q;
    frame_error_d = 1'b0;

    // A mode change takes priority over a coincident tick and restarts framing.
    if ((mode != mode_q) || !is_relay(mode)) begin
      state_d    = ST_LISTEN;
      hist_d     = 24'h000000;
      bit_cnt_d  = 3'd0;
      tick_cnt_d = 12'd0;
    end else if (tick) begin
      hist_d    = hist_shift;
      bit_cnt_d = bit_inc;
      if (state_q == ST_LISTEN) begin
        if (start_hit) begin
          state_d    = ST_MOD;
          bit_cnt_d  = 3'd0;
          tick_cnt_d = 12'd0;
        end
      end else begin
        tick_cnt_d = tick_inc;
        if (tick_inc == TICKS_MAX) begin
          state_d       = ST_LISTEN;
          frame_error_d = 1'b1;
        end else if (end_hit && (bit_inc == 3'd0)) begin
          state_d = ST_LISTEN;
        end
      end
    end

    case (mode)
      MODE_FAKE_READER: mod_type_d = (state_d == ST_MOD) ? MODE_READER_MOD : MODE_READER_LISTEN;
      MODE_FAKE_TAG:    mod_type_d = (state_d == ST_MOD) ? MODE_TAGSIM_MOD : MODE_TAGSIM_LISTEN;
      default:          mod_type_d = mode;
    endcase
  end

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      div_q         <= 4'd0;
      mode_q        <= MODE_SNIFFER;
      state_q       <= ST_LISTEN;
      hist_q        <= 24'h000000;
      bit_cnt_q     <= 3'd0;
      tick_cnt_q    <= 12'd0;
      mod_type_q    <= 3'b000;
      bit_strobe_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      mode_q        <= mode;
      state_q       <= state_d;
      hist_q        <= hist_d;
      bit_cnt_q     <= bit_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      mod_type_q    <= mod_type_d;
      bit_strobe_q  <= tick;
      frame_error_q <= frame_error_d;
    end
  end

  assign mod_type     = mod_type_q;
  assign data_bit     = hist_q[7];
  assign bit_strobe   = bit_strobe_q;
  assign frame_active = (state_q == ST_MOD);
  assign frame_error  = frame_error_q;

endmodule
